rtc_scan_display: RTL and testbench

Parametrised successor to the single-mode HH:MM:SS timekeeper/display top. It keeps BCD time of day from a parametrised 1 Hz prescaler and supports 12/24-hour display and a validated time-set handshake. It drives one shared, polarity-configurable 7-segment bus across NUM_DIGITS anodes, with anti-ghosting guard time. It sits between the board clock/pins and user set logic.

---
 rtl/rtc_pkg.sv | 36 +++
 rtl/seven_seg_decode.sv | 15 +
 rtl/rtc_scan_display.sv | 220 ++++++++++++++++++++++
 tb/tb_rtc_scan_display.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and helpers for the BCD time-of-day keeper and its multiplexed display.
package rtc_pkg;

   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;
   localparam logic [7:0] HR_MAX  = 8'h23;

   localparam int DIGITS_HHMMSS = 6;
   localparam int DIGITS_HHMM   = 4;

   // {g,f,e,d,c,b,a} patterns, element n is digit n
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef struct packed {
      logic [7:0] hh;
      logic [7:0] mm;
      logic [7:0] ss;
   } bcd_time_t;

   function automatic bit digits_legal(input int n);
      return (n == DIGITS_HHMMSS) || (n == DIGITS_HHMM);
   endfunction

   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD nibble to active-high {g,f,e,d,c,b,a}; blank or non-decimal input turns all segments off.
module seven_seg_decode
   import rtc_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = 7'h00;
      if (!blank_i && (nib_i <= 4'd9)) seg_o = SEG_TABLE[nib_i];
   end

endmodule

// File: rtl/rtc_scan_display.sv
// BCD time-of-day keeper with validated set handshake, 12/24-hour display and a
// guarded, polarity-configurable multiplexed 7-segment scanner.
module rtc_scan_display
   import rtc_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int SCAN_DIV   = 65536,
   parameter int GUARD      = 16,
   parameter int NUM_DIGITS = 6,
   parameter int AN_ACT_LOW = 1,
   parameter int SEG_ACT_LOW = 1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RUN,
   input  logic                  MODE12,
   input  logic                  BLANK_LZ,
   input  logic                  SET_VALID,
   output logic                  SET_READY,
   input  logic [7:0]            SET_HH,
   input  logic [7:0]            SET_MM,
   input  logic [7:0]            SET_SS,
   output logic                  SET_ERR,
   output logic                  TICK_1HZ,
   output logic [23:0]           TIME_BCD,
   output logic [6:0]            SEG,
   output logic                  DP,
   output logic [NUM_DIGITS-1:0] AN
);

   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] GUARD_END  = DW'(GUARD);
   localparam logic [2:0]    IDX_LAST   = 3'(NUM_DIGITS - 1);
   localparam bit            SIX        = (NUM_DIGITS == DIGITS_HHMMSS);
   // a 4-digit display skips the two seconds positions of the digit map
   localparam logic [2:0]    POS_OFS    =
      3'(digits_legal(NUM_DIGITS) ? (DIGITS_HHMMSS - NUM_DIGITS) : 0);

   localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACT_LOW != 0) ? '1 : '0;
   localparam logic [6:0]            SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = (SEG_ACT_LOW != 0);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CHECK = 1'b1;

   logic [PW-1:0]         presc_q, presc_d;
   bcd_time_t             time_q, time_d;
   logic                  tick_q, tick_d;
   logic [0:0]            state_q, state_d;
   logic                  ready_q;
   logic                  err_q, err_d;
   bcd_time_t             cap_q, cap_d;
   logic [DW-1:0]         dwell_q, dwell_d;
   logic [2:0]            idx_q, idx_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic       wrap, cap_ok, load, dwell_wrap, pm;
   logic [7:0] hr_disp;
   logic [2:0] pos;
   logic [3:0] nib;
   logic       nib_blank, dp_raw;
   logic [6:0] seg_raw;

   function automatic bcd_time_t time_inc(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.ss == SEC_MAX) begin
         r.ss = 8'h00;
         if (t.mm == MIN_MAX) begin
            r.mm = 8'h00;
            r.hh = (t.hh == HR_MAX) ? 8'h00 : bcd_inc(t.hh);
         end else begin
            r.mm = bcd_inc(t.mm);
         end
      end else begin
         r.ss = bcd_inc(t.ss);
      end
      return r;
   endfunction

   function automatic logic [7:0] hour12(input logic [7:0] h);
      if (h == 8'h00) return 8'h12;
      if (h >= 8'h22) return {4'd1, h[3:0] - 4'd2};
      if (h >= 8'h20) return {4'd0, h[3:0] + 4'd8};
      if (h >= 8'h13) return {4'd0, h[3:0] - 4'd2};
      return h;
   endfunction

   assign wrap   = RUN && (presc_q == PRESC_LAST);
   assign cap_ok = bcd_ok(cap_q.hh, HR_MAX) && bcd_ok(cap_q.mm, MIN_MAX) &&
                   bcd_ok(cap_q.ss, SEC_MAX);
   assign load   = (state_q == ST_CHECK) && cap_ok;

   // a validated load overrides any tick landing on the same edge
   always_comb begin
      presc_d = presc_q;
      time_d  = time_q;
      tick_d  = 1'b0;
      if (load) begin
         presc_d = '0;
         time_d  = cap_q;
      end else if (!RUN) begin
         presc_d = '0;
      end else if (wrap) begin
         presc_d = '0;
         time_d  = time_inc(time_q);
         tick_d  = 1'b1;
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (SET_VALID && ready_q) begin
               cap_d   = {SET_HH, SET_MM, SET_SS};
               state_d = ST_CHECK;
            end
         end
         default: begin
            err_d   = !cap_ok;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign pm      = (time_q.hh >= 8'h12);
   assign hr_disp = MODE12 ? hour12(time_q.hh) : time_q.hh;
   assign pos     = idx_q + POS_OFS;

   always_comb begin
      nib       = 4'd0;
      nib_blank = 1'b0;
      dp_raw    = 1'b0;
      case (pos)
         3'd0: nib = time_q.ss[3:0];
         3'd1: nib = time_q.ss[7:4];
         3'd2: begin
            nib    = time_q.mm[3:0];
            dp_raw = SIX && !time_q.ss[0];
         end
         3'd3: nib = time_q.mm[7:4];
         3'd4: begin
            nib    = hr_disp[3:0];
            dp_raw = MODE12 && pm;
         end
         default: begin
            nib       = hr_disp[7:4];
            nib_blank = BLANK_LZ && (hr_disp[7:4] == 4'd0);
         end
      endcase
   end

   seven_seg_decode u_dec (
      .nib_i   (nib),
      .blank_i (nib_blank),
      .seg_o   (seg_raw)
   );

   assign dwell_wrap = (dwell_q == DWELL_LAST);

   always_comb begin
      dwell_d = dwell_wrap ? '0 : dwell_q + DW'(1);
      idx_d   = idx_q;
      if (dwell_wrap) idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
      an_d  = ((dwell_q >= GUARD_END) ? (NUM_DIGITS'(1) << idx_q) : '0) ^ AN_OFF;
      seg_d = seg_raw ^ SEG_OFF;
      dp_d  = dp_raw ^ DP_OFF;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         presc_q <= '0;
         time_q  <= '0;
         tick_q  <= 1'b0;
         state_q <= ST_IDLE;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         dwell_q <= '0;
         idx_q   <= '0;
         an_q    <= AN_OFF;
         seg_q   <= SEG_OFF;
         dp_q    <= DP_OFF;
      end else begin
         presc_q <= presc_d;
         time_q  <= time_d;
         tick_q  <= tick_d;
         state_q <= state_d;
         ready_q <= (state_d == ST_IDLE);
         err_q   <= err_d;
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   always_ff @(posedge CLK) begin
      cap_q <= cap_d;
   end

   assign SET_READY = ready_q;
   assign SET_ERR   = err_q;
   assign TICK_1HZ  = tick_q;
   assign TIME_BCD  = time_q;
   assign SEG       = seg_q;
   assign DP        = dp_q;
   assign AN        = an_q;

endmodule

// File: tb/tb_rtc_scan_display.sv
// Directed bench: a 6-digit active-low and a 4-digit active-high instance driven from shared inputs.
module tb_rtc_scan_display;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RUN = 1'b1, MODE12 = 1'b0, BLANK_LZ = 1'b0, SET_VALID = 1'b0;
   logic [7:0] SET_HH = 8'h00, SET_MM = 8'h00, SET_SS = 8'h00;

   logic        rdy6, err6, tick6, dp6;
   logic [23:0] time6;
   logic [6:0]  seg6;
   logic [5:0]  an6;
   logic        rdy4, err4, tick4, dp4;
   logic [23:0] time4;
   logic [6:0]  seg4;
   logic [3:0]  an4;

   int n_chk = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   rtc_scan_display #(.CLK_HZ(10), .SCAN_DIV(8), .GUARD(2), .NUM_DIGITS(6),
                      .AN_ACT_LOW(1), .SEG_ACT_LOW(1)) u6 (
      .CLK(CLK), .RST(RST), .RUN(RUN), .MODE12(MODE12), .BLANK_LZ(BLANK_LZ),
      .SET_VALID(SET_VALID), .SET_READY(rdy6), .SET_HH(SET_HH), .SET_MM(SET_MM),
      .SET_SS(SET_SS), .SET_ERR(err6), .TICK_1HZ(tick6), .TIME_BCD(time6),
      .SEG(seg6), .DP(dp6), .AN(an6)
   );

   rtc_scan_display #(.CLK_HZ(10), .SCAN_DIV(8), .GUARD(2), .NUM_DIGITS(4),
                      .AN_ACT_LOW(0), .SEG_ACT_LOW(0)) u4 (
      .CLK(CLK), .RST(RST), .RUN(RUN), .MODE12(MODE12), .BLANK_LZ(BLANK_LZ),
      .SET_VALID(SET_VALID), .SET_READY(rdy4), .SET_HH(SET_HH), .SET_MM(SET_MM),
      .SET_SS(SET_SS), .SET_ERR(err4), .TICK_1HZ(tick4), .TIME_BCD(time4),
      .SEG(seg4), .DP(dp4), .AN(an4)
   );

   typedef struct {
      logic [23:0] setv;
      logic        m12;
      logic        blz;
      logic        err;
      logic [23:0] tm;
      logic [3:0]  ht;
      logic [3:0]  ho;
      logic        dph;
   } vec_t;

   vec_t vt [13];

   function automatic logic [6:0] pat(input logic [3:0] d);
      case (d)
         4'd0: pat = 7'h3F;
         4'd1: pat = 7'h06;
         4'd2: pat = 7'h5B;
         4'd3: pat = 7'h4F;
         4'd4: pat = 7'h66;
         4'd5: pat = 7'h6D;
         4'd6: pat = 7'h7D;
         4'd7: pat = 7'h07;
         4'd8: pat = 7'h7F;
         4'd9: pat = 7'h6F;
         default: pat = 7'h00;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic set_req(input logic [23:0] v);
      {SET_HH, SET_MM, SET_SS} = v;
      SET_VALID = 1'b1;
      @(posedge CLK);
      #1;
      SET_VALID = 1'b0;
   endtask

   task automatic chk_reset();
      chk("rst time6", time6, 24'h0);
      chk("rst time4", time4, 24'h0);
      chk("rst ready", {rdy6, rdy4}, 2'b00);
      chk("rst err", {err6, err4}, 2'b00);
      chk("rst tick", {tick6, tick4}, 2'b00);
      chk("rst an6", an6, 6'h3F);
      chk("rst seg6/dp6", {seg6, dp6}, 8'hFF);
      chk("rst an4", an4, 4'h0);
      chk("rst seg4/dp4", {seg4, dp4}, 8'h00);
   endtask

   task automatic scan_vec(input vec_t v);
      logic [3:0] d6 [6];
      logic [3:0] d4 [4];
      logic [6:0] es;
      logic       ed;
      bit         ok;
      d6[0] = v.tm[3:0];   d6[1] = v.tm[7:4];
      d6[2] = v.tm[11:8];  d6[3] = v.tm[15:12];
      d6[4] = v.ho;        d6[5] = v.ht;
      d4[0] = v.tm[11:8];  d4[1] = v.tm[15:12];
      d4[2] = v.ho;        d4[3] = v.ht;
      for (int k = 0; k < 6; k++) begin
         ok = 1'b0;
         for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge CLK);
            if (an6 == ~(6'd1 << k)) ok = 1'b1;
         end
         chk($sformatf("scan6 reach idx%0d", k), ok, 1);
         es = ~pat(d6[k]);
         ed = ~((k == 2) ? ~v.tm[0] : (k == 4) ? v.dph : 1'b0);
         chk($sformatf("seg6 idx%0d", k), seg6, es);
         chk($sformatf("dp6 idx%0d", k), dp6, ed);
      end
      for (int k = 0; k < 4; k++) begin
         ok = 1'b0;
         for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge CLK);
            if (an4 == (4'd1 << k)) ok = 1'b1;
         end
         chk($sformatf("scan4 reach idx%0d", k), ok, 1);
         es = pat(d4[k]);
         ed = (k == 2) ? v.dph : 1'b0;
         chk($sformatf("seg4 idx%0d", k), seg4, es);
         chk($sformatf("dp4 idx%0d", k), dp4, ed);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int z6, o6, bad6, last6, z4, o4, bad4, last4, ix;

      vt[0]  = '{24'h123456, 1'b0, 1'b0, 1'b0, 24'h123456, 4'h1, 4'h2, 1'b0};
      vt[1]  = '{24'h000500, 1'b1, 1'b0, 1'b0, 24'h000500, 4'h1, 4'h2, 1'b0};
      vt[2]  = '{24'h120000, 1'b1, 1'b0, 1'b0, 24'h120000, 4'h1, 4'h2, 1'b1};
      vt[3]  = '{24'h130700, 1'b1, 1'b0, 1'b0, 24'h130700, 4'h0, 4'h1, 1'b1};
      vt[4]  = '{24'h130700, 1'b1, 1'b1, 1'b0, 24'h130700, 4'hF, 4'h1, 1'b1};
      vt[5]  = '{24'h235958, 1'b1, 1'b1, 1'b0, 24'h235958, 4'h1, 4'h1, 1'b1};
      vt[6]  = '{24'h083001, 1'b0, 1'b1, 1'b0, 24'h083001, 4'hF, 4'h8, 1'b0};
      vt[7]  = '{24'h096000, 1'b0, 1'b0, 1'b1, 24'h083001, 4'h0, 4'h8, 1'b0};
      vt[8]  = '{24'h09000A, 1'b1, 1'b1, 1'b1, 24'h083001, 4'hF, 4'h8, 1'b0};
      vt[9]  = '{24'h240000, 1'b0, 1'b0, 1'b1, 24'h083001, 4'h0, 4'h8, 1'b0};
      vt[10] = '{24'h1A0000, 1'b1, 1'b0, 1'b1, 24'h083001, 4'h0, 4'h8, 1'b0};
      vt[11] = '{24'h201559, 1'b1, 1'b0, 1'b0, 24'h201559, 4'h0, 4'h8, 1'b1};
      vt[12] = '{24'h000000, 1'b0, 1'b1, 1'b0, 24'h000000, 4'hF, 4'h0, 1'b0};

      // reset state, then first second and first minute from release
      repeat (3) @(posedge CLK);
      #1;
      chk_reset();
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         cyc(1);
         if (i == 1) chk("ready on first clock", rdy6, 1);
         chk($sformatf("tick at cycle %0d", i), tick6, (i == 10));
      end
      chk("time after 10 cycles", time6, 24'h000001);
      cyc(589);
      chk("time after 599 cycles", time6, 24'h000059);
      cyc(1);
      chk("time after 600 cycles", time6, 24'h000100);
      chk("tick at cycle 600", tick6, 1);

      // full carry chain across midnight
      set_req(24'h235958);
      cyc(1);
      chk("set 23:59:58", time6, 24'h235958);
      cyc(9);
      chk("no early tick", {tick6, time6}, {1'b0, 24'h235958});
      cyc(1);
      chk("tick to 23:59:59", {tick6, time6}, {1'b1, 24'h235959});
      cyc(9);
      chk("hold 23:59:59", time6, 24'h235959);
      cyc(1);
      chk("midnight wrap", {tick6, time6}, {1'b1, 24'h000000});

      // load lands on the wrap edge: load wins, no tick
      set_req(24'h010203);
      cyc(1);
      chk("set 01:02:03", time6, 24'h010203);
      cyc(8);
      set_req(24'h050607);
      cyc(1);
      chk("load beats tick", {tick6, time6}, {1'b0, 24'h050607});
      cyc(9);
      chk("prescaler restarted", {tick6, time6}, {1'b0, 24'h050607});
      cyc(1);
      chk("tick after load", {tick6, time6}, {1'b1, 24'h050608});

      // table: set handshake, 12/24h, blanking and full digit map with time frozen
      RUN = 1'b0;
      for (int i = 0; i < 13; i++) begin
         MODE12 = vt[i].m12;
         BLANK_LZ = vt[i].blz;
         set_req(vt[i].setv);
         chk($sformatf("v%0d ready low in check", i), rdy6, 0);
         cyc(1);
         chk($sformatf("v%0d set_err", i), err6, vt[i].err);
         chk($sformatf("v%0d ready back", i), rdy6, 1);
         chk($sformatf("v%0d time", i), time6, vt[i].tm);
         cyc(1);
         chk($sformatf("v%0d set_err one cycle", i), err6, 0);
         scan_vec(vt[i]);
         chk($sformatf("v%0d time frozen", i), time6, vt[i].tm);
         chk($sformatf("v%0d time 4-digit", i), time4, vt[i].tm);
      end

      // anode activity and index order over three full scan periods
      z6 = 0; o6 = 0; bad6 = 0; last6 = -1;
      z4 = 0; o4 = 0; bad4 = 0; last4 = -1;
      for (int c = 0; c < 96; c++) begin
         @(negedge CLK);
         if ($countones(~an6) == 0) z6++;
         else if ($countones(~an6) == 1) begin
            o6++;
            ix = $clog2(~an6);
            if (ix != last6) begin
               if (last6 >= 0 && ix != (last6 + 1) % 6) bad6++;
               last6 = ix;
            end
         end
         if ($countones(an4) == 0) z4++;
         else if ($countones(an4) == 1) begin
            o4++;
            ix = $clog2(an4);
            if (ix != last4) begin
               if (last4 >= 0 && ix != (last4 + 1) % 4) bad4++;
               last4 = ix;
            end
         end
      end
      chk("an6 guard cycles", z6, 24);
      chk("an6 one-hot cycles", o6, 72);
      chk("an6 index order", bad6, 0);
      chk("an4 guard cycles", z4, 24);
      chk("an4 one-hot cycles", o4, 72);
      chk("an4 index order", bad4, 0);

      // prescaler was held at zero while frozen
      RUN = 1'b1;
      cyc(9);
      chk("resume no tick yet", {tick6, time6}, {1'b0, 24'h000000});
      cyc(1);
      chk("resume first tick", {tick6, time6}, {1'b1, 24'h000001});

      // asynchronous reset mid-check, then mid-count
      for (int r = 0; r < 2; r++) begin
         if (r == 0) begin
            set_req(24'h111111);
            #2;
         end else begin
            cyc(37);
            #3;
         end
         RST = 1'b0;
         #1;
         chk_reset();
         @(negedge CLK);
         RST = 1'b1;
         cyc(1);
         chk($sformatf("reset%0d ready first clock", r), rdy6, 1);
         chk($sformatf("reset%0d time zero", r), time6, 24'h000000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule
